// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data memory between the CPU port (0) and the
// DMA/debug port (1). One access at a time runs IDLE -> ACCESS -> RESP,
// with a round-robin grant when both ports ask and an address range guard.
module dmem_arbiter #(
  parameter int DEPTH  = 1024,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [DATA_W-1:0] addr0,
  input  logic [DATA_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic              err0,
  output logic              err1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_writeData,
  output logic              mem_memWrite,
  output logic              mem_memRead,
  input  logic [DATA_W-1:0] mem_readData
);

  localparam logic [DATA_W-1:0] DEPTH_W = DATA_W'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

  state_t state_q, state_d;

  // Latched request attributes for the access in flight
  logic              prio_q, prio_d;
  logic              id_q, id_d;
  logic              we_q, we_d;
  logic              oor_q, oor_d;

  // Registered outputs; mem_address/mem_writeData double as the address/data latch
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              mem_we_q, mem_we_d;
  logic              mem_re_q, mem_re_d;
  logic              ack0_q, ack0_d, ack1_q, ack1_d;
  logic              err0_q, err0_d, err1_q, err1_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;

  // Winner selection: lone requester wins, otherwise the prio pointer decides
  logic              gnt_valid;
  logic              gnt_id;
  logic              gnt_we;
  logic [DATA_W-1:0] gnt_addr;
  logic [DATA_W-1:0] gnt_wdata;
  logic              gnt_oor;
  logic [DATA_W-1:0] result;

  assign gnt_valid = req0 | req1;
  assign gnt_id    = (req0 & req1) ? prio_q : req1;
  assign gnt_we    = gnt_id ? we1 : we0;
  assign gnt_addr  = gnt_id ? addr1 : addr0;
  assign gnt_wdata = gnt_id ? wdata1 : wdata0;
  assign gnt_oor   = (gnt_addr >= DEPTH_W);
  // Writes and rejected accesses return zero regardless of what memory shows
  assign result    = (we_q | oor_q) ? '0 : mem_readData;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic: each access takes exactly one ACCESS and one RESP cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (gnt_valid) state_d = S_ACCESS;
      S_ACCESS: state_d = S_RESP;
      S_RESP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Output logic: next values for the latches and every registered output
  always_comb begin
    prio_d   = prio_q;
    id_d     = id_q;
    we_d     = we_q;
    oor_d    = oor_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    mem_we_d = 1'b0;
    mem_re_d = 1'b0;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    err0_d   = 1'b0;
    err1_d   = 1'b0;
    rdata0_d = '0;
    rdata1_d = '0;
    case (state_q)
      S_IDLE: begin
        if (gnt_valid) begin
          id_d     = gnt_id;
          we_d     = gnt_we;
          oor_d    = gnt_oor;
          addr_d   = gnt_addr;
          wdata_d  = gnt_wdata;
          mem_we_d = gnt_we & ~gnt_oor;
          mem_re_d = ~gnt_we & ~gnt_oor;
        end
      end
      S_ACCESS: begin
        addr_d  = '0;
        wdata_d = '0;
        if (id_q) begin
          ack1_d   = 1'b1;
          err1_d   = oor_q;
          rdata1_d = result;
        end else begin
          ack0_d   = 1'b1;
          err0_d   = oor_q;
          rdata0_d = result;
        end
      end
      S_RESP: prio_d = ~id_q;
      default: ;
    endcase
  end

  // Output and latch registers; reset clears everything so an aborted access never acks
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prio_q   <= 1'b0;
      id_q     <= 1'b0;
      we_q     <= 1'b0;
      oor_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      mem_we_q <= 1'b0;
      mem_re_q <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      err0_q   <= 1'b0;
      err1_q   <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      prio_q   <= prio_d;
      id_q     <= id_d;
      we_q     <= we_d;
      oor_q    <= oor_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      mem_we_q <= mem_we_d;
      mem_re_q <= mem_re_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      err0_q   <= err0_d;
      err1_q   <= err1_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  assign ack0          = ack0_q;
  assign ack1          = ack1_q;
  assign err0          = err0_q;
  assign err1          = err1_q;
  assign rdata0        = rdata0_q;
  assign rdata1        = rdata1_q;
  assign mem_address   = addr_q;
  assign mem_writeData = wdata_q;
  assign mem_memWrite  = mem_we_q;
  assign mem_memRead   = mem_re_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed scenarios against dmem_arbiter with a simple
// word memory attached (combinational read, write on posedge).
// Memory word i starts as 0xA0000000 + i.
module tb_dmem_arbiter;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [DW-1:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
  logic          ack0, ack1, err0, err1;
  logic [DW-1:0] rdata0, rdata1;
  logic [DW-1:0] mem_address, mem_writeData, mem_readData;
  logic          mem_memWrite, mem_memRead;
  logic          tb_init = 1'b1;
  logic [DW-1:0] tb_mem [0:1023];

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.DEPTH(1024), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1),
    .rdata0(rdata0), .rdata1(rdata1),
    .mem_address(mem_address), .mem_writeData(mem_writeData),
    .mem_memWrite(mem_memWrite), .mem_memRead(mem_memRead),
    .mem_readData(mem_readData)
  );

  // Memory model: preload on the first edge, then write when enabled
  always @(posedge clk) begin
    if (tb_init) begin
      for (int i = 0; i < 1024; i++) tb_mem[i] <= 32'hA000_0000 + i;
    end else if (mem_memWrite) begin
      tb_mem[mem_address[9:0]] <= mem_writeData;
    end
  end
  assign mem_readData = tb_mem[mem_address[9:0]];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'd3;
    tick();
    tb_init = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({ack0, ack1, err0, err1, mem_memWrite, mem_memRead} !== 6'b0 ||
          rdata0 !== '0 || rdata1 !== '0 || mem_address !== '0 || mem_writeData !== '0) begin
        n_mis++;
        $display("FAIL reset_outputs: ack0=%b ack1=%b err0=%b err1=%b memW=%b memR=%b rdata0=%h rdata1=%h addr=%h wd=%h, required all 0",
                 ack0, ack1, err0, err1, mem_memWrite, mem_memRead, rdata0, rdata1, mem_address, mem_writeData);
      end
    end
    @(negedge clk);
    rst = 1'b1;
    tick();
    n_cmp++;
    if (mem_memRead !== 1'b1 || mem_address !== 32'd3) begin
      n_mis++;
      $display("FAIL reset_first_grant: memRead=%b addr=%h, required 1 / 3", mem_memRead, mem_address);
    end
    tick();
    n_cmp++;
    if (ack0 !== 1'b1 || err0 !== 1'b0 || ack1 !== 1'b0 || rdata0 !== 32'hA000_0003) begin
      n_mis++;
      $display("FAIL reset_first_ack: ack0=%b err0=%b ack1=%b rdata0=%h, required 1/0/0/a0000003", ack0, err0, ack1, rdata0);
    end
    tick();
    n_cmp++;
    if (ack0 !== 1'b0) begin
      n_mis++;
      $display("FAIL reset_ack_pulse: ack0=%b, required 0", ack0);
    end
    req0 = 1'b0;
    $display("test_reset done: compared=%0d mismatched=%0d", n_cmp, n_mis);
  endtask

  task automatic test_write_read_p0();
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'd5; wdata0 = 32'hDEAD_BEEF;
    tick();
    n_cmp++;
    if (mem_memWrite !== 1'b1 || mem_memRead !== 1'b0 || mem_address !== 32'd5 || mem_writeData !== 32'hDEAD_BEEF) begin
      n_mis++;
      $display("FAIL wr_mem_drive: memW=%b memR=%b addr=%h wd=%h, required 1/0/5/deadbeef",
               mem_memWrite, mem_memRead, mem_address, mem_writeData);
    end
    tick();
    n_cmp++;
    if (ack0 !== 1'b1 || err0 !== 1'b0 || rdata0 !== '0 || mem_memWrite !== 1'b0) begin
      n_mis++;
      $display("FAIL wr_ack: ack0=%b err0=%b rdata0=%h memW=%b, required 1/0/0/0", ack0, err0, rdata0, mem_memWrite);
    end
    tick();
    we0 = 1'b0;
    tick();
    n_cmp++;
    if (mem_memRead !== 1'b1 || mem_memWrite !== 1'b0 || mem_address !== 32'd5) begin
      n_mis++;
      $display("FAIL rd_mem_drive: memR=%b memW=%b addr=%h, required 1/0/5", mem_memRead, mem_memWrite, mem_address);
    end
    tick();
    n_cmp++;
    if (ack0 !== 1'b1 || err0 !== 1'b0 || rdata0 !== 32'hDEAD_BEEF) begin
      n_mis++;
      $display("FAIL rd_ack: ack0=%b err0=%b rdata0=%h, required 1/0/deadbeef", ack0, err0, rdata0);
    end
    tick();
    req0 = 1'b0;
    $display("test_write_read_p0 done: compared=%0d mismatched=%0d", n_cmp, n_mis);
  endtask

  task automatic test_simultaneous();
    rst = 1'b0;
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'd1;
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'd2;
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      logic          exp_p;
      logic [DW-1:0] exp_addr;
      exp_p    = (k % 2 == 1);
      exp_addr = exp_p ? 32'd2 : 32'd1;
      tick();
      n_cmp++;
      if (mem_memRead !== 1'b1 || mem_address !== exp_addr) begin
        n_mis++;
        $display("FAIL alt_grant[%0d]: memR=%b addr=%h, required 1/%h", k, mem_memRead, mem_address, exp_addr);
      end
      tick();
      n_cmp++;
      if (ack0 !== !exp_p || ack1 !== exp_p ||
          rdata0 !== (exp_p ? 32'h0 : 32'hA000_0001) || rdata1 !== (exp_p ? 32'hA000_0002 : 32'h0)) begin
        n_mis++;
        $display("FAIL alt_ack[%0d]: ack0=%b ack1=%b rdata0=%h rdata1=%h, required winner port %0d",
                 k, ack0, ack1, rdata0, rdata1, exp_p);
      end
      tick();
      n_cmp++;
      if (ack0 !== 1'b0 || ack1 !== 1'b0) begin
        n_mis++;
        $display("FAIL alt_idle[%0d]: ack0=%b ack1=%b, required 0/0", k, ack0, ack1);
      end
      if (k == 3) begin
        req0 = 1'b0;
        req1 = 1'b0;
      end
    end
    $display("test_simultaneous done: compared=%0d mismatched=%0d", n_cmp, n_mis);
  endtask

  task automatic test_out_of_range();
    // Last valid word
    req1 = 1'b1; we1 = 1'b1; addr1 = 32'd1023; wdata1 = 32'h55AA_55AA;
    tick();
    n_cmp++;
    if (mem_memWrite !== 1'b1 || mem_address !== 32'd1023) begin
      n_mis++;
      $display("FAIL edge_write_drive: memW=%b addr=%h, required 1/3ff", mem_memWrite, mem_address);
    end
    tick();
    n_cmp++;
    if (ack1 !== 1'b1 || err1 !== 1'b0 || rdata1 !== '0) begin
      n_mis++;
      $display("FAIL edge_write_ack: ack1=%b err1=%b rdata1=%h, required 1/0/0", ack1, err1, rdata1);
    end
    tick();
    // First invalid word
    addr1 = 32'd1024; wdata1 = 32'h1234_5678;
    tick();
    n_cmp++;
    if (mem_memWrite !== 1'b0 || mem_memRead !== 1'b0) begin
      n_mis++;
      $display("FAIL oor_write_drive: memW=%b memR=%b, required 0/0", mem_memWrite, mem_memRead);
    end
    tick();
    n_cmp++;
    if (ack1 !== 1'b1 || err1 !== 1'b1 || rdata1 !== '0 || ack0 !== 1'b0 || mem_memWrite !== 1'b0) begin
      n_mis++;
      $display("FAIL oor_write_ack: ack1=%b err1=%b rdata1=%h ack0=%b memW=%b, required 1/1/0/0/0",
               ack1, err1, rdata1, ack0, mem_memWrite);
    end
    tick();
    // Largest address, read: memory shows a nonzero word but result must be 0
    we1 = 1'b0; addr1 = 32'hFFFF_FFFF;
    tick();
    n_cmp++;
    if (mem_memWrite !== 1'b0 || mem_memRead !== 1'b0) begin
      n_mis++;
      $display("FAIL oor_read_drive: memW=%b memR=%b, required 0/0", mem_memWrite, mem_memRead);
    end
    tick();
    n_cmp++;
    if (ack1 !== 1'b1 || err1 !== 1'b1 || rdata1 !== '0) begin
      n_mis++;
      $display("FAIL oor_read_ack: ack1=%b err1=%b rdata1=%h, required 1/1/0", ack1, err1, rdata1);
    end
    tick();
    req1 = 1'b0;
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'd0;
    tick();
    tick();
    n_cmp++;
    if (ack0 !== 1'b1 || err0 !== 1'b0 || rdata0 !== 32'hA000_0000) begin
      n_mis++;
      $display("FAIL oor_followup_read: ack0=%b err0=%b rdata0=%h, required 1/0/a0000000", ack0, err0, rdata0);
    end
    tick();
    req0 = 1'b0;
    $display("test_out_of_range done: compared=%0d mismatched=%0d", n_cmp, n_mis);
  endtask

  task automatic test_reset_mid_access();
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'd4;
    tick();
    n_cmp++;
    if (mem_memRead !== 1'b1 || mem_address !== 32'd4) begin
      n_mis++;
      $display("FAIL abort_grant: memR=%b addr=%h, required 1/4", mem_memRead, mem_address);
    end
    #1;
    rst = 1'b0;
    #1;
    n_cmp++;
    if (mem_memRead !== 1'b0 || mem_memWrite !== 1'b0 || mem_address !== '0 || ack0 !== 1'b0 || rdata0 !== '0) begin
      n_mis++;
      $display("FAIL abort_clear: memR=%b memW=%b addr=%h ack0=%b rdata0=%h, required all 0",
               mem_memRead, mem_memWrite, mem_address, ack0, rdata0);
    end
    tick();
    n_cmp++;
    if (ack0 !== 1'b0 || ack1 !== 1'b0) begin
      n_mis++;
      $display("FAIL abort_no_ack: ack0=%b ack1=%b, required 0/0", ack0, ack1);
    end
    @(negedge clk);
    rst = 1'b1;
    req0 = 1'b0;
    tick();
    n_cmp++;
    if (ack0 !== 1'b0 || mem_memRead !== 1'b0) begin
      n_mis++;
      $display("FAIL abort_idle: ack0=%b memR=%b, required 0/0", ack0, mem_memRead);
    end
    req0 = 1'b1; addr0 = 32'd6;
    tick();
    n_cmp++;
    if (mem_memRead !== 1'b1 || mem_address !== 32'd6) begin
      n_mis++;
      $display("FAIL abort_regrant: memR=%b addr=%h, required 1/6", mem_memRead, mem_address);
    end
    tick();
    n_cmp++;
    if (ack0 !== 1'b1 || rdata0 !== 32'hA000_0006) begin
      n_mis++;
      $display("FAIL abort_reack: ack0=%b rdata0=%h, required 1/a0000006", ack0, rdata0);
    end
    tick();
    req0 = 1'b0;
    $display("test_reset_mid_access done: compared=%0d mismatched=%0d", n_cmp, n_mis);
  endtask

  task automatic test_input_change();
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'd3;
    tick();
    addr0 = 32'd7;
    n_cmp++;
    if (mem_address !== 32'd3 || mem_memRead !== 1'b1) begin
      n_mis++;
      $display("FAIL latch_addr: addr=%h memR=%b, required 3/1", mem_address, mem_memRead);
    end
    tick();
    n_cmp++;
    if (ack0 !== 1'b1 || rdata0 !== 32'hA000_0003) begin
      n_mis++;
      $display("FAIL latch_data: ack0=%b rdata0=%h, required 1/a0000003", ack0, rdata0);
    end
    tick();
    req0 = 1'b0;
    $display("test_input_change done: compared=%0d mismatched=%0d", n_cmp, n_mis);
  endtask

  initial begin
    test_reset();
    test_write_read_p0();
    test_simultaneous();
    test_out_of_range();
    test_reset_mid_access();
    test_input_change();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
